ycr_dmem_tcm_splitter: RTL and testbench
========================================

# ycr_dmem_tcm_splitter

Core-side data-memory splitter feeding the TCM router's dmem port. Decodes each core dmem request by address, forwards it to either the TCM path or the external (system bus) dmem path, and returns responses to the core in request order. A 2-entry tag FIFO tracks outstanding requests so the core can issue back-to-back accesses across both targets.

## Interface
- TCM_ADDR_MASK, 32'hFFFF_F800, address bits compared for TCM window (2 KB)
- TCM_ADDR_PATTERN, 32'h0C48_0000, TCM window base; hit = (addr & MASK) == PATTERN
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- core_dmem_req  in  1  request valid
- core_dmem_req_ack  out  1  request accepted this cycle
- core_dmem_cmd  in  1  0 = read, 1 = write
- core_dmem_width  in  2  BYTE/HWORD/WORD
- core_dmem_addr  in  32  byte address
- core_dmem_wdata  in  32  write data
- core_dmem_rdata  out  32  read data
- core_dmem_resp  out  2  NOTRDY/RDY_OK/RDY_ER
- tcm_dmem_req, tcm_dmem_cmd, tcm_dmem_width, tcm_dmem_addr, tcm_dmem_wdata  out  1/1/2/32/32  TCM-path request
- tcm_dmem_req_ack  in  1 ; tcm_dmem_rdata  in  32 ; tcm_dmem_resp  in  2
- ext_dmem_req, ext_dmem_cmd, ext_dmem_width, ext_dmem_addr, ext_dmem_wdata  out  1/1/2/32/32  external-path request
- ext_dmem_req_ack  in  1 ; ext_dmem_rdata  in  32 ; ext_dmem_resp  in  2

## Operation
- Tag FIFO: depth 2, 2-bit entries: 2'b00 TCM, 2'b01 EXT, 2'b10 LOCAL_ERR. Pointers wrap mod 2; count 0..2.
- Decode: hit_tcm from mask/pattern; miss -> EXT.
- Forward: selected port req = core_dmem_req & ~full & ~blk; cmd/width/addr/wdata driven to both ports unconditionally (unused port sees req=0).
- Accept: core_dmem_req_ack = selected port req_ack & ~full. On accept push target tag.
- Response: head tag selects source. core_dmem_resp/rdata = head port resp/rdata; pop when that resp != NOTRDY. Responses from non-head port are ignored (protocol violation; not asserted).
- LOCAL_ERR head: core_dmem_resp = RDY_ER, rdata = 0, pop same cycle.
- FIFO empty: core_dmem_resp = NOTRDY, core_dmem_rdata = 0.
- Push and pop in same cycle allowed, count unchanged; at full, pop frees a slot only next cycle (no bypass).
- Reset: FIFO cleared, count 0; all outputs combinationally 0 (req_ack 0, port reqs 0, resp NOTRDY, rdata 0). Port responses arriving after mid-operation reset are dropped.

## Timing
- Request path combinational: core req to port req 0 cycles; port req_ack to core req_ack 0 cycles.
- Response path combinational from port resp to core resp; splitter adds 0 cycles latency.
- LOCAL_ERR response: earliest cycle after accept (entry must reach head).
- Max 2 outstanding; third request stalls (req_ack 0) until a pop registers.
- Tag FIFO updates on posedge clk; async clear on negedge rst_n.

## Configuration
- YCR_DMEM_MISALIGN_ERR_EN defined: misaligned access (HWORD with addr[0]=1, WORD with addr[1:0]!=0) is not forwarded (blk=1); splitter accepts it itself when ~full, pushes LOCAL_ERR, returns RDY_ER.
- Undefined: blk=0; misaligned requests forwarded unchanged to the decoded port; no LOCAL_ERR tags generated.

## Test plan
- Reset then idle: all outputs 0, resp NOTRDY; word read 0x0C48_0010, TCM acks, resp OK with 0xDEAD_BEEF next cycle -> core_dmem_rdata 0xDEAD_BEEF, resp OK, FIFO empty.
- Write 0x2000_0000 (EXT) then read 0x0C48_0004 (TCM) back-to-back; TCM responds first, EXT two cycles later -> core sees EXT OK first, then TCM data; early TCM resp held until EXT pops.
- Three requests with no responses -> third req_ack=0 until first resp pops; then accepted next cycle.
- EXT returns RDY_ER on read 0x3000_0000 -> core resp RDY_ER, entry popped.
- Macro on: HWORD write to 0x0C48_0001 -> no port req, req_ack=1, next cycle resp RDY_ER; macro off: tcm_dmem_req=1 with addr 0x0C48_0001.
- rst_n low with 2 outstanding, then TCM resp OK after release -> core resp stays NOTRDY, count 0.

Source files
------------

// File: rtl/ycr_dmem_tcm_splitter.sv
// ycr_dmem_tcm_splitter: routes core dmem requests to TCM or external port and returns responses in order.
// Define YCR_DMEM_MISALIGN_ERR_EN to answer misaligned accesses locally with RDY_ER.
module ycr_dmem_tcm_splitter #(
    parameter logic [31:0] TCM_ADDR_MASK    = 32'hFFFF_F800,
    parameter logic [31:0] TCM_ADDR_PATTERN = 32'h0C48_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_dmem_req,
    output logic        core_dmem_req_ack,
    input  logic        core_dmem_cmd,
    input  logic [1:0]  core_dmem_width,
    input  logic [31:0] core_dmem_addr,
    input  logic [31:0] core_dmem_wdata,
    output logic [31:0] core_dmem_rdata,
    output logic [1:0]  core_dmem_resp,
    output logic        tcm_dmem_req,
    input  logic        tcm_dmem_req_ack,
    output logic        tcm_dmem_cmd,
    output logic [1:0]  tcm_dmem_width,
    output logic [31:0] tcm_dmem_addr,
    output logic [31:0] tcm_dmem_wdata,
    input  logic [31:0] tcm_dmem_rdata,
    input  logic [1:0]  tcm_dmem_resp,
    output logic        ext_dmem_req,
    input  logic        ext_dmem_req_ack,
    output logic        ext_dmem_cmd,
    output logic [1:0]  ext_dmem_width,
    output logic [31:0] ext_dmem_addr,
    output logic [31:0] ext_dmem_wdata,
    input  logic [31:0] ext_dmem_rdata,
    input  logic [1:0]  ext_dmem_resp
);
    localparam logic [1:0] TAG_TCM = 2'b00, TAG_EXT = 2'b01, TAG_ERR = 2'b10;
    localparam logic [1:0] RESP_NOTRDY = 2'd0, RESP_ER = 2'd2;
    logic [1:0]  tags [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic        hit_tcm, blk, full, empty, push, pop;
    logic [1:0]  head, head_resp, push_tag;
    logic [31:0] head_rdata;
    assign hit_tcm = (core_dmem_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN;
`ifdef YCR_DMEM_MISALIGN_ERR_EN
    assign blk = (core_dmem_width == 2'b01 && core_dmem_addr[0]) ||
                 (core_dmem_width == 2'b10 && core_dmem_addr[1:0] != 2'b00);
`else
    assign blk = 1'b0;
`endif
    assign full  = count == 2'd2;
    assign empty = count == 2'd0;
    assign {tcm_dmem_cmd, tcm_dmem_width, tcm_dmem_addr, tcm_dmem_wdata} =
           {core_dmem_cmd, core_dmem_width, core_dmem_addr, core_dmem_wdata};
    assign {ext_dmem_cmd, ext_dmem_width, ext_dmem_addr, ext_dmem_wdata} =
           {core_dmem_cmd, core_dmem_width, core_dmem_addr, core_dmem_wdata};
    always_comb begin
        tcm_dmem_req      = rst_n & core_dmem_req & ~full & ~blk & hit_tcm;
        ext_dmem_req      = rst_n & core_dmem_req & ~full & ~blk & ~hit_tcm;
        core_dmem_req_ack = rst_n & core_dmem_req & ~full &
                            (blk | (hit_tcm ? tcm_dmem_req_ack : ext_dmem_req_ack));
        push              = core_dmem_req_ack;
        push_tag          = blk ? TAG_ERR : hit_tcm ? TAG_TCM : TAG_EXT;
        head              = tags[rd_ptr];
        head_resp         = head == TAG_TCM ? tcm_dmem_resp : head == TAG_EXT ? ext_dmem_resp : RESP_ER;
        head_rdata        = head == TAG_TCM ? tcm_dmem_rdata : head == TAG_EXT ? ext_dmem_rdata : 32'd0;
        core_dmem_resp    = (rst_n & ~empty) ? head_resp : RESP_NOTRDY;
        core_dmem_rdata   = (rst_n & ~empty) ? head_rdata : 32'd0;
        pop               = ~empty & (head_resp != RESP_NOTRDY);
    end
    // full is registered, so a pop at full only frees a slot for the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tags[0] <= TAG_TCM;
            tags[1] <= TAG_TCM;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= push_tag;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_ycr_dmem_tcm_splitter.sv
// tb_ycr_dmem_tcm_splitter: directed scenarios with hand-computed expectations for the dmem splitter.
module tb_ycr_dmem_tcm_splitter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        core_dmem_req, core_dmem_req_ack, core_dmem_cmd;
    logic [1:0]  core_dmem_width, core_dmem_resp;
    logic [31:0] core_dmem_addr, core_dmem_wdata, core_dmem_rdata;
    logic        tcm_dmem_req, tcm_dmem_req_ack, tcm_dmem_cmd;
    logic [1:0]  tcm_dmem_width, tcm_dmem_resp;
    logic [31:0] tcm_dmem_addr, tcm_dmem_wdata, tcm_dmem_rdata;
    logic        ext_dmem_req, ext_dmem_req_ack, ext_dmem_cmd;
    logic [1:0]  ext_dmem_width, ext_dmem_resp;
    logic [31:0] ext_dmem_addr, ext_dmem_wdata, ext_dmem_rdata;
    int passed = 0, total = 0;

    ycr_dmem_tcm_splitter dut (
        .clk(clk), .rst_n(rst_n),
        .core_dmem_req(core_dmem_req), .core_dmem_req_ack(core_dmem_req_ack),
        .core_dmem_cmd(core_dmem_cmd), .core_dmem_width(core_dmem_width),
        .core_dmem_addr(core_dmem_addr), .core_dmem_wdata(core_dmem_wdata),
        .core_dmem_rdata(core_dmem_rdata), .core_dmem_resp(core_dmem_resp),
        .tcm_dmem_req(tcm_dmem_req), .tcm_dmem_req_ack(tcm_dmem_req_ack),
        .tcm_dmem_cmd(tcm_dmem_cmd), .tcm_dmem_width(tcm_dmem_width),
        .tcm_dmem_addr(tcm_dmem_addr), .tcm_dmem_wdata(tcm_dmem_wdata),
        .tcm_dmem_rdata(tcm_dmem_rdata), .tcm_dmem_resp(tcm_dmem_resp),
        .ext_dmem_req(ext_dmem_req), .ext_dmem_req_ack(ext_dmem_req_ack),
        .ext_dmem_cmd(ext_dmem_cmd), .ext_dmem_width(ext_dmem_width),
        .ext_dmem_addr(ext_dmem_addr), .ext_dmem_wdata(ext_dmem_wdata),
        .ext_dmem_rdata(ext_dmem_rdata), .ext_dmem_resp(ext_dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_dmem_req = 0; core_dmem_cmd = 0; core_dmem_width = 0; core_dmem_addr = 0; core_dmem_wdata = 0;
        tcm_dmem_req_ack = 0; tcm_dmem_resp = 0; tcm_dmem_rdata = 0;
        ext_dmem_req_ack = 0; ext_dmem_resp = 0; ext_dmem_rdata = 0;
    endtask

    task automatic req(input logic c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        core_dmem_req = 1; core_dmem_cmd = c; core_dmem_width = w; core_dmem_addr = a; core_dmem_wdata = d;
    endtask

    task automatic test_reset();
        idle();
        req(0, 2'd2, 32'h0C48_0010, 32'h0);
        tcm_dmem_req_ack = 1; tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h1234_5678; ext_dmem_resp = 1;
        #3;
        total++; if (core_dmem_req_ack !== 1'b0) $display("FAIL rst_req_ack: got %b exp 0", core_dmem_req_ack); else passed++;
        total++; if (tcm_dmem_req !== 1'b0) $display("FAIL rst_tcm_req: got %b exp 0", tcm_dmem_req); else passed++;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL rst_resp: got %0d exp 0", core_dmem_resp); else passed++;
        total++; if (core_dmem_rdata !== 32'h0) $display("FAIL rst_rdata: got %h exp 0", core_dmem_rdata); else passed++;
        idle();
        step(); step();
        rst_n = 1;
        #1;
        total++; if ({core_dmem_req_ack, tcm_dmem_req, ext_dmem_req} !== 3'b000) $display("FAIL idle_reqs: got %b exp 000", {core_dmem_req_ack, tcm_dmem_req, ext_dmem_req}); else passed++;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL idle_resp: got %0d exp 0", core_dmem_resp); else passed++;
        total++; if (core_dmem_rdata !== 32'h0) $display("FAIL idle_rdata: got %h exp 0", core_dmem_rdata); else passed++;
    endtask

    task automatic test_tcm_read();
        step(); idle();
        req(0, 2'd2, 32'h0C48_0010, 32'h0); tcm_dmem_req_ack = 1;
        #1;
        total++; if ({tcm_dmem_req, ext_dmem_req, core_dmem_req_ack} !== 3'b101) $display("FAIL tcmrd_req: got %b exp 101", {tcm_dmem_req, ext_dmem_req, core_dmem_req_ack}); else passed++;
        total++; if (tcm_dmem_addr !== 32'h0C48_0010) $display("FAIL tcmrd_addr: got %h exp 0c480010", tcm_dmem_addr); else passed++;
        step(); idle();
        tcm_dmem_resp = 1; tcm_dmem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (core_dmem_resp !== 2'd1) $display("FAIL tcmrd_resp: got %0d exp 1", core_dmem_resp); else passed++;
        total++; if (core_dmem_rdata !== 32'hDEAD_BEEF) $display("FAIL tcmrd_rdata: got %h exp deadbeef", core_dmem_rdata); else passed++;
        step(); idle();
        tcm_dmem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL tcmrd_empty_resp: got %0d exp 0", core_dmem_resp); else passed++;
        total++; if (core_dmem_rdata !== 32'h0) $display("FAIL tcmrd_empty_rdata: got %h exp 0", core_dmem_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        step(); idle();
        req(1, 2'd2, 32'h2000_0000, 32'hCAFE_F00D); ext_dmem_req_ack = 1;
        #1;
        total++; if ({tcm_dmem_req, ext_dmem_req, core_dmem_req_ack} !== 3'b011) $display("FAIL b2b_ext_req: got %b exp 011", {tcm_dmem_req, ext_dmem_req, core_dmem_req_ack}); else passed++;
        total++; if ({ext_dmem_cmd, ext_dmem_wdata} !== {1'b1, 32'hCAFE_F00D}) $display("FAIL b2b_ext_wdata: got %h exp 1cafef00d", {ext_dmem_cmd, ext_dmem_wdata}); else passed++;
        step(); idle();
        req(0, 2'd2, 32'h0C48_0004, 32'h0); tcm_dmem_req_ack = 1;
        #1;
        total++; if ({tcm_dmem_req, ext_dmem_req, core_dmem_req_ack} !== 3'b101) $display("FAIL b2b_tcm_req: got %b exp 101", {tcm_dmem_req, ext_dmem_req, core_dmem_req_ack}); else passed++;
        for (int i = 0; i < 2; i++) begin
            step(); idle();
            tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h1111_2222;
            #1;
            total++; if (core_dmem_resp !== 2'd0) $display("FAIL b2b_hold%0d: got %0d exp 0", i, core_dmem_resp); else passed++;
        end
        step(); idle();
        tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h1111_2222; ext_dmem_resp = 1; ext_dmem_rdata = 32'hAAAA_5555;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== {2'd1, 32'hAAAA_5555}) $display("FAIL b2b_ext_first: got %h exp 1aaaa5555", {core_dmem_resp, core_dmem_rdata}); else passed++;
        step(); idle();
        tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h1111_2222;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== {2'd1, 32'h1111_2222}) $display("FAIL b2b_tcm_second: got %h exp 111112222", {core_dmem_resp, core_dmem_rdata}); else passed++;
        step(); idle();
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL b2b_drained: got %0d exp 0", core_dmem_resp); else passed++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(); idle();
            req(0, 2'd2, 32'h0C48_0020, 32'h0); tcm_dmem_req_ack = 1;
            #1;
            total++; if (core_dmem_req_ack !== 1'b1) $display("FAIL stall_acc%0d: got %b exp 1", i, core_dmem_req_ack); else passed++;
        end
        step(); idle();
        req(0, 2'd2, 32'h2000_0100, 32'h0); ext_dmem_req_ack = 1;
        #1;
        total++; if ({ext_dmem_req, core_dmem_req_ack} !== 2'b00) $display("FAIL stall_full: got %b exp 00", {ext_dmem_req, core_dmem_req_ack}); else passed++;
        step(); idle();
        req(0, 2'd2, 32'h2000_0100, 32'h0); ext_dmem_req_ack = 1; tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h0000_00A1;
        #1;
        total++; if ({core_dmem_req_ack, core_dmem_resp} !== 3'b001) $display("FAIL stall_pop_no_bypass: got %b exp 001", {core_dmem_req_ack, core_dmem_resp}); else passed++;
        step(); idle();
        req(0, 2'd2, 32'h2000_0100, 32'h0); ext_dmem_req_ack = 1;
        #1;
        total++; if ({ext_dmem_req, core_dmem_req_ack} !== 2'b11) $display("FAIL stall_release: got %b exp 11", {ext_dmem_req, core_dmem_req_ack}); else passed++;
        step(); idle();
        tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h0000_00A2;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== {2'd1, 32'h0000_00A2}) $display("FAIL stall_drain_tcm: got %h exp 1000000a2", {core_dmem_resp, core_dmem_rdata}); else passed++;
        step(); idle();
        ext_dmem_resp = 1; ext_dmem_rdata = 32'h0000_00B1;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== {2'd1, 32'h0000_00B1}) $display("FAIL stall_drain_ext: got %h exp 1000000b1", {core_dmem_resp, core_dmem_rdata}); else passed++;
        step(); idle();
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL stall_empty: got %0d exp 0", core_dmem_resp); else passed++;
    endtask

    task automatic test_ext_error();
        step(); idle();
        req(0, 2'd2, 32'h3000_0000, 32'h0); ext_dmem_req_ack = 1;
        #1;
        total++; if ({ext_dmem_req, core_dmem_req_ack} !== 2'b11) $display("FAIL exterr_req: got %b exp 11", {ext_dmem_req, core_dmem_req_ack}); else passed++;
        step(); idle();
        ext_dmem_resp = 2;
        #1;
        total++; if (core_dmem_resp !== 2'd2) $display("FAIL exterr_resp: got %0d exp 2", core_dmem_resp); else passed++;
        step(); idle();
        ext_dmem_resp = 2;
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL exterr_popped: got %0d exp 0", core_dmem_resp); else passed++;
    endtask

    task automatic test_misalign();
        step(); idle();
        req(1, 2'd1, 32'h0C48_0001, 32'h0000_BEEF);
`ifdef YCR_DMEM_MISALIGN_ERR_EN
        #1;
        total++; if ({tcm_dmem_req, ext_dmem_req, core_dmem_req_ack} !== 3'b001) $display("FAIL mis_local_ack: got %b exp 001", {tcm_dmem_req, ext_dmem_req, core_dmem_req_ack}); else passed++;
        step(); idle();
        tcm_dmem_rdata = 32'hFFFF_FFFF;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== {2'd2, 32'h0}) $display("FAIL mis_local_err: got %h exp 200000000", {core_dmem_resp, core_dmem_rdata}); else passed++;
`else
        #1;
        total++; if ({tcm_dmem_req, core_dmem_req_ack} !== 2'b10) $display("FAIL mis_fwd_req: got %b exp 10", {tcm_dmem_req, core_dmem_req_ack}); else passed++;
        total++; if (tcm_dmem_addr !== 32'h0C48_0001) $display("FAIL mis_fwd_addr: got %h exp 0c480001", tcm_dmem_addr); else passed++;
        tcm_dmem_req_ack = 1;
        #1;
        total++; if (core_dmem_req_ack !== 1'b1) $display("FAIL mis_fwd_ack: got %b exp 1", core_dmem_req_ack); else passed++;
        step(); idle();
        tcm_dmem_resp = 1;
        #1;
        total++; if (core_dmem_resp !== 2'd1) $display("FAIL mis_fwd_resp: got %0d exp 1", core_dmem_resp); else passed++;
`endif
        step(); idle();
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL mis_empty: got %0d exp 0", core_dmem_resp); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            step(); idle();
            req(0, 2'd2, 32'h0C48_0040, 32'h0); tcm_dmem_req_ack = 1;
        end
        step(); idle();
        rst_n = 0; tcm_dmem_resp = 1; tcm_dmem_rdata = 32'h5555_AAAA;
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL midrst_resp_low: got %0d exp 0", core_dmem_resp); else passed++;
        step(); step();
        rst_n = 1;
        #1;
        total++; if ({core_dmem_resp, core_dmem_rdata} !== 34'h0) $display("FAIL midrst_dropped: got %h exp 0", {core_dmem_resp, core_dmem_rdata}); else passed++;
        for (int i = 0; i < 3; i++) begin
            step(); idle();
            req(0, 2'd2, 32'h0C48_0044, 32'h0); tcm_dmem_req_ack = 1;
            #1;
            total++; if (core_dmem_req_ack !== (i < 2)) $display("FAIL midrst_count%0d: got %b exp %b", i, core_dmem_req_ack, i < 2); else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            step(); idle();
            tcm_dmem_resp = 1;
        end
        step(); idle();
        #1;
        total++; if (core_dmem_resp !== 2'd0) $display("FAIL midrst_drained: got %0d exp 0", core_dmem_resp); else passed++;
    endtask

    initial begin
        test_reset();
        test_tcm_read();
        test_back_to_back();
        test_stall();
        test_ext_error();
        test_misalign();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
